// File: rtl/unary_array_pkg.sv
// rtl/unary_array_pkg.sv - shared defaults, ifm type and feeder FSM encoding
package unary_array_pkg;

  localparam int DEF_HEIGHT = 32;
  localparam int DEF_IWIDTH = 16;
  localparam int DEF_CWIDTH = 16;

  typedef logic signed [DEF_IWIDTH-1:0] ifm_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } feed_state_t;

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - D-stage shift register, D=0 degenerates to a wire
module skew_line #(
  parameter int D = 1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (D == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] sr [D];

    // Shift the control word one stage per clock, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < D; i++) sr[i] <= '0;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[D-1];
  end

endmodule

// File: rtl/ifm_skew_feeder.sv
// rtl/ifm_skew_feeder.sv - diagonally skewed ifm feeder for the systolic array (optional IFM_ZERO_SKIP_EN)
module ifm_skew_feeder
  import unary_array_pkg::*;
#(
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int IWIDTH = DEF_IWIDTH,
  parameter int CWIDTH = DEF_CWIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] in_ifm [HEIGHT],
  input  logic        [CWIDTH-1:0] mac_len,
  output logic signed [IWIDTH-1:0] ifm [HEIGHT],
  output logic        [HEIGHT-1:0] en_i,
  output logic        [HEIGHT-1:0] clr_i,
  output logic        [HEIGHT-1:0] mac_done,
  output logic                     busy
);

  localparam logic [CWIDTH-1:0] LMIN = CWIDTH'(HEIGHT);

  feed_state_t               state;
  logic        [CWIDTH-1:0]  cnt;
  logic        [CWIDTH-1:0]  lm1;
  logic signed [IWIDTH-1:0]  vec_q [HEIGHT];
  logic                      accept;
  logic                      nx_en;
  logic                      nx_done;
  logic        [3:0]         ctl_src;
  logic        [3:0]         ctl_d [HEIGHT];

  // Ready depends only on state/counter: RUN opens only on its last cycle
  assign in_ready = (state != RUN) || (cnt == lm1);
  assign accept   = in_valid && in_ready;

  // Row-0 control one cycle ahead of the outputs; the row registers add that cycle
  assign nx_en   = accept || ((state == RUN) && (cnt != lm1));
  assign nx_done = (state == RUN) && (cnt == lm1 - CWIDTH'(1));
  assign ctl_src = {accept, nx_en, nx_done, accept};

  assign busy = (state != IDLE) || (|en_i);

  // Sequencer: hold each vector for L cycles, then drain the skew for HEIGHT-1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      lm1   <= LMIN - CWIDTH'(1);
    end else if (accept) begin
      state <= RUN;
      cnt   <= '0;
      lm1   <= (mac_len < LMIN) ? (LMIN - CWIDTH'(1)) : (mac_len - CWIDTH'(1));
    end else begin
      case (state)
        RUN: begin
          if (cnt == lm1) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CWIDTH'(1);
          end
        end
        DRAIN: begin
          if (cnt == CWIDTH'(HEIGHT - 2)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CWIDTH'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Vector register; the clamp keeps it stable until the last row has loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < HEIGHT; h++) vec_q[h] <= '0;
    end else if (accept) begin
      vec_q <= in_ifm;
    end
  end

  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    logic signed [IWIDTH-1:0] src;
    logic signed [IWIDTH-1:0] ifm_q;
    logic                     clr_q;
    logic                     en_q;
    logic                     done_q;
    logic                     zero;

    skew_line #(.D(h), .W(4)) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ctl_src),
      .q     (ctl_d[h])
    );

    // Row 0 loads on the accept edge itself, before vec_q has the data
    assign src = (h == 0) ? in_ifm[h] : vec_q[h];

`ifdef IFM_ZERO_SKIP_EN
    logic skip_q;
    assign zero = ctl_d[h][0] ? (src == '0) : skip_q;

    // Remember per vector whether this row's element is zero
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             skip_q <= 1'b0;
      else if (ctl_d[h][0])   skip_q <= (src == '0);
    end
`else
    assign zero = 1'b0;
`endif

    // Output registers for this row, driven by its skewed control word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        clr_q  <= 1'b0;
        en_q   <= 1'b0;
        done_q <= 1'b0;
        ifm_q  <= '0;
      end else begin
        clr_q  <= ctl_d[h][3];
        en_q   <= ctl_d[h][2] & ~zero;
        done_q <= ctl_d[h][1];
        if (ctl_d[h][0]) ifm_q <= src;
      end
    end

    assign clr_i[h]    = clr_q;
    assign en_i[h]     = en_q;
    assign mac_done[h] = done_q;
    assign ifm[h]      = ifm_q;
  end

endmodule

// File: tb/tb_ifm_skew_feeder.sv
// tb/tb_ifm_skew_feeder.sv - directed self-checking bench for ifm_skew_feeder
module tb_ifm_skew_feeder;
  import unary_array_pkg::*;

  localparam int H  = DEF_HEIGHT;
  localparam int IW = DEF_IWIDTH;
  localparam int CW = DEF_CWIDTH;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] in_ifm [H];
  logic        [CW-1:0] mac_len;
  logic signed [IW-1:0] ifm [H];
  logic        [H-1:0]  en_i;
  logic        [H-1:0]  clr_i;
  logic        [H-1:0]  mac_done;
  logic                 busy;

  logic signed [IW-1:0] stim [H];

  int total = 0;
  int bad   = 0;

  int clr_cnt [H], clr_first [H], clr_second [H];
  int done_cnt [H], done_first [H];
  int en_cnt [H], en_first [H], en_last [H];
  logic signed [IW-1:0] ifm_at_done [H];
  int busy_last, rdy_low, acc_cnt;
  int acc_rel [8];

  ifm_skew_feeder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ifm   (in_ifm),
    .mac_len  (mac_len),
    .ifm      (ifm),
    .en_i     (en_i),
    .clr_i    (clr_i),
    .mac_done (mac_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_rec();
    for (int h = 0; h < H; h++) begin
      clr_cnt[h] = 0; clr_first[h] = -1; clr_second[h] = -1;
      done_cnt[h] = 0; done_first[h] = -1;
      en_cnt[h] = 0; en_first[h] = -1; en_last[h] = -1;
      ifm_at_done[h] = '0;
    end
    busy_last = -1; rdy_low = 0; acc_cnt = 0;
  endtask

  // Accepts stim with the given length; rel cycle 1 is the first output cycle
  task automatic start(input int len, input bit hold);
    int w = 0;
    while (!in_ready && w < 300) begin @(posedge clk); #1; w++; end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL start_ready: in_ready=%0b required 1", in_ready); end
    in_ifm = stim; mac_len = CW'(len); in_valid = 1'b1;
    @(posedge clk); #1;
    clear_rec();
    acc_cnt = 1; acc_rel[0] = 0;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic observe(input int n, input int inject_rel, input int max_acc);
    bit drop = 0;
    for (int i = 1; i <= n; i++) begin
      for (int h = 0; h < H; h++) begin
        if (clr_i[h]) begin
          clr_cnt[h]++;
          if (clr_cnt[h] == 1) clr_first[h] = i;
          else if (clr_cnt[h] == 2) clr_second[h] = i;
        end
        if (mac_done[h]) begin
          done_cnt[h]++;
          if (done_cnt[h] == 1) done_first[h] = i;
          ifm_at_done[h] = ifm[h];
        end
        if (en_i[h]) begin
          en_cnt[h]++;
          if (en_first[h] < 0) en_first[h] = i;
          en_last[h] = i;
        end
      end
      if (busy) busy_last = i;
      if (!in_ready) rdy_low++;
      if (i == inject_rel) in_valid = 1'b1;
      if (in_valid && in_ready && acc_cnt < 8) begin
        acc_rel[acc_cnt] = i;
        acc_cnt++;
        if (acc_cnt >= max_acc) drop = 1;
      end
      @(posedge clk); #1;
      if (drop) begin in_valid = 1'b0; drop = 0; end
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy || !in_ready) && w < 400) begin @(posedge clk); #1; w++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wait_idle: busy=%0b required 0", busy); end
  endtask

  task automatic test_reset();
    int nz;
    rst_n = 1'b0; in_valid = 1'b0; mac_len = '0;
    for (int h = 0; h < H; h++) begin in_ifm[h] = '0; stim[h] = '0; end
    repeat (3) @(posedge clk);
    #1;
    nz = 0;
    for (int h = 0; h < H; h++) if (ifm[h] !== '0) nz++;
    total++; if (en_i !== '0) begin bad++; $display("FAIL reset_en: en_i=%h required 0", en_i); end
    total++; if (clr_i !== '0) begin bad++; $display("FAIL reset_clr: clr_i=%h required 0", clr_i); end
    total++; if (mac_done !== '0) begin bad++; $display("FAIL reset_done: mac_done=%h required 0", mac_done); end
    total++; if (nz !== 0) begin bad++; $display("FAIL reset_ifm: nonzero rows=%0d required 0", nz); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: busy=%0b required 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: in_ready=%0b required 1", in_ready); end
  endtask

  task automatic test_single();
    for (int h = 0; h < H; h++) stim[h] = IW'(h + 1);
    start(64, 0);
    observe(64 + H + 8, -1, 1);
    total++; if (clr_first[0] !== 1) begin bad++; $display("FAIL single_clr0: cycle=%0d required 1", clr_first[0]); end
    total++; if (done_first[0] !== 64) begin bad++; $display("FAIL single_done0: cycle=%0d required 64", done_first[0]); end
    total++; if (clr_first[31] !== 32) begin bad++; $display("FAIL single_clr31: cycle=%0d required 32", clr_first[31]); end
    total++; if (done_first[31] !== 95) begin bad++; $display("FAIL single_done31: cycle=%0d required 95", done_first[31]); end
    total++; if (en_cnt[31] !== 64) begin bad++; $display("FAIL single_en31: count=%0d required 64", en_cnt[31]); end
    total++; if (clr_cnt[0] !== 1) begin bad++; $display("FAIL single_clrcnt0: count=%0d required 1", clr_cnt[0]); end
    total++; if (ifm_at_done[0] !== 16'sd1) begin bad++; $display("FAIL single_ifm0: value=%0d required 1", ifm_at_done[0]); end
    total++; if (ifm_at_done[31] !== 16'sd32) begin bad++; $display("FAIL single_ifm31: value=%0d required 32", ifm_at_done[31]); end
    total++; if (ifm[31] !== 16'sd32) begin bad++; $display("FAIL single_ifm31_hold: value=%0d required 32", ifm[31]); end
    total++; if (busy_last !== 95) begin bad++; $display("FAIL single_busy: last cycle=%0d required 95", busy_last); end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    for (int h = 0; h < H; h++) stim[h] = IW'(-3 * h - 7);
    start(40, 1);
    observe(120 + H + 8, -1, 3);
    total++; if (acc_cnt !== 3) begin bad++; $display("FAIL b2b_accepts: count=%0d required 3", acc_cnt); end
    total++; if (acc_rel[1] !== 40) begin bad++; $display("FAIL b2b_acc1: cycle=%0d required 40", acc_rel[1]); end
    total++; if (acc_rel[2] !== 80) begin bad++; $display("FAIL b2b_acc2: cycle=%0d required 80", acc_rel[2]); end
    total++; if (en_cnt[5] !== 120) begin bad++; $display("FAIL b2b_en5_cnt: count=%0d required 120", en_cnt[5]); end
    total++; if (en_last[5] - en_first[5] !== 119) begin bad++; $display("FAIL b2b_en5_span: span=%0d required 119", en_last[5] - en_first[5]); end
    total++; if (done_first[5] !== 45) begin bad++; $display("FAIL b2b_done5: cycle=%0d required 45", done_first[5]); end
    total++; if (clr_second[5] !== 46) begin bad++; $display("FAIL b2b_clr5_next: cycle=%0d required 46", clr_second[5]); end
    total++; if (ifm_at_done[5] !== IW'(-22)) begin bad++; $display("FAIL b2b_ifm5: value=%0d required -22", ifm_at_done[5]); end
  endtask

  task automatic test_clamp();
    wait_idle();
    for (int h = 0; h < H; h++) stim[h] = IW'(100 + h);
    start(3, 0);
    observe(32 + H + 8, -1, 1);
    total++; if (en_cnt[0] !== 32) begin bad++; $display("FAIL clamp_en0: count=%0d required 32", en_cnt[0]); end
    total++; if (rdy_low !== 31) begin bad++; $display("FAIL clamp_ready_low: count=%0d required 31", rdy_low); end
    total++; if (done_first[0] !== 32) begin bad++; $display("FAIL clamp_done0: cycle=%0d required 32", done_first[0]); end
    total++; if (done_first[31] - clr_first[31] !== 31) begin bad++; $display("FAIL clamp_row31_len: gap=%0d required 31", done_first[31] - clr_first[31]); end
  endtask

  task automatic test_drain_accept();
    wait_idle();
    for (int h = 0; h < H; h++) stim[h] = IW'(h * 2);
    start(32, 0);
    observe(80, 42, 2);
    total++; if (acc_rel[1] !== 42) begin bad++; $display("FAIL drain_acc: cycle=%0d required 42", acc_rel[1]); end
    total++; if (clr_second[0] !== 43) begin bad++; $display("FAIL drain_clr0_new: cycle=%0d required 43", clr_second[0]); end
    total++; if (done_first[31] !== 63) begin bad++; $display("FAIL drain_done31_old: cycle=%0d required 63", done_first[31]); end
    total++; if (clr_second[31] !== 74) begin bad++; $display("FAIL drain_clr31_new: cycle=%0d required 74", clr_second[31]); end
  endtask

  task automatic test_zero_skip();
    wait_idle();
    for (int h = 0; h < H; h++) stim[h] = IW'(5);
    stim[7] = '0;
    start(32, 0);
    observe(32 + H + 8, -1, 1);
    total++; if (clr_first[7] !== 8) begin bad++; $display("FAIL zs_clr7: cycle=%0d required 8", clr_first[7]); end
    total++; if (done_first[7] !== 39) begin bad++; $display("FAIL zs_done7: cycle=%0d required 39", done_first[7]); end
    total++; if (en_cnt[6] !== 32) begin bad++; $display("FAIL zs_en6: count=%0d required 32", en_cnt[6]); end
`ifdef IFM_ZERO_SKIP_EN
    total++; if (en_cnt[7] !== 0) begin bad++; $display("FAIL zs_en7: count=%0d required 0", en_cnt[7]); end
`else
    total++; if (en_cnt[7] !== 32) begin bad++; $display("FAIL zs_en7: count=%0d required 32", en_cnt[7]); end
`endif
  endtask

  task automatic test_reset_mid_run();
    int nz, dsum, esum;
    wait_idle();
    for (int h = 0; h < H; h++) stim[h] = IW'(h + 9);
    start(100, 0);
    observe(20, -1, 1);
    rst_n = 1'b0;
    #1;
    nz = 0;
    for (int h = 0; h < H; h++) if (ifm[h] !== '0) nz++;
    total++; if (en_i !== '0) begin bad++; $display("FAIL rst_mid_en: en_i=%h required 0", en_i); end
    total++; if (clr_i !== '0 || mac_done !== '0) begin bad++; $display("FAIL rst_mid_ctl: clr_i=%h mac_done=%h required 0", clr_i, mac_done); end
    total++; if (nz !== 0) begin bad++; $display("FAIL rst_mid_ifm: nonzero rows=%0d required 0", nz); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: busy=%0b required 0", busy); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: in_ready=%0b required 1", in_ready); end
    clear_rec();
    observe(150, -1, 1);
    dsum = 0; esum = 0;
    for (int h = 0; h < H; h++) begin dsum += done_cnt[h]; esum += en_cnt[h]; end
    total++; if (dsum !== 0) begin bad++; $display("FAIL rst_mid_no_done: count=%0d required 0", dsum); end
    total++; if (esum !== 0) begin bad++; $display("FAIL rst_mid_no_en: count=%0d required 0", esum); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clamp();
    test_drain_accept();
    test_zero_skip();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
